ccu_mul_shift_seq: RTL

Parametrised successor to the CCU 2 multiply/shift control unit.
- Sequences an operation over N minor cycles instead of exactly one.
- Operation types: multiply, shift-left and shift-right.
- Configurable word length (pulse intervals per minor cycle) and stimulus delay.
- Sits in the control section between the order decoder (c5/c6/c7/s2) and the arithmetic unit; generates digit-timed gates and a completion pulse.

---
 rtl/ccu_mul_shift_seq_if.sv | 45 ++++
 rtl/ccu_mul_shift_seq.sv | 130 +++++++++++++
 2 files changed

// File: rtl/ccu_mul_shift_seq_if.sv
// Order/data bus between the CCU control section and ccu_mul_shift_seq.
// The abort line exists only when CCU_MUL_SHIFT_ABORT_EN is defined.
interface ccu_mul_shift_seq_if #(
  parameter int CNT_W = 6,
  parameter int POS_W = 6
);
`ifdef CCU_MUL_SHIFT_ABORT_EN
  logic             abort;
`endif
  logic             d0;
  logic             mcand_in;
  logic             c5;
  logic             c6;
  logic             c7;
  logic             s2;
  logic             da;
  logic [1:0]       mode;
  logic [CNT_W-1:0] shift_count;
  logic             zero_d0;
  logic             g8;
  logic             da_m;
  logic             ds;
  logic             mult_step;
  logic             shift_l;
  logic             shift_r;
  logic             busy;
  logic             done;
  logic [POS_W-1:0] digit_pos;

  modport master (
`ifdef CCU_MUL_SHIFT_ABORT_EN
    output abort,
`endif
    output d0, mcand_in, c5, c6, c7, s2, da, mode, shift_count,
    input  zero_d0, g8, da_m, ds, mult_step, shift_l, shift_r, busy, done, digit_pos
  );

  modport slave (
`ifdef CCU_MUL_SHIFT_ABORT_EN
    input  abort,
`endif
    input  d0, mcand_in, c5, c6, c7, s2, da, mode, shift_count,
    output zero_d0, g8, da_m, ds, mult_step, shift_l, shift_r, busy, done, digit_pos
  );
endinterface

// File: rtl/ccu_mul_shift_seq.sv
// ccu_mul_shift_seq: multi-minor-cycle multiply/shift sequencer for the CCU.
// Stimulus from the order decoder arms the block; it runs shift_count minor
// cycles from the next d0 and ends with a one-p.i. done pulse.
// Optional abort input enabled by defining CCU_MUL_SHIFT_ABORT_EN.
module ccu_mul_shift_seq #(
  parameter int WORD_LEN   = 36,
  parameter int STIM_DELAY = 1,
  parameter int CNT_W      = 6
) (
  input logic                clk,
  input logic                rst_n,
  ccu_mul_shift_seq_if.slave bus
);
  localparam int POS_W = $clog2(WORD_LEN);

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_ACTIVE, S_DONE} state_t;
  typedef enum logic [1:0] {M_MUL = 2'b00, M_SHL = 2'b01, M_SHR = 2'b10, M_RSV = 2'b11} mode_t;

  state_t                r_state;
  mode_t                 r_mode;
  logic [CNT_W-1:0]      r_step;
  logic [POS_W-1:0]      r_pos;
  logic [STIM_DELAY-1:0] r_stim;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_mult;
  logic                  r_shl;
  logic                  r_shr;

  state_t                w_state_nxt;
  mode_t                 w_mode_nxt;
  logic [CNT_W-1:0]      w_step_nxt;
  logic [CNT_W-1:0]      w_load_step;
  logic                  w_stim;
  logic                  w_ff_set;
  logic                  w_last;
  logic                  w_abort;
  logic                  w_zero_d0;

`ifdef CCU_MUL_SHIFT_ABORT_EN
  assign w_abort = bus.abort;
`else
  assign w_abort = 1'b0;
`endif

  assign w_stim      = (bus.mcand_in & bus.c5) | (bus.c6 & bus.s2);
  assign w_ff_set    = r_stim[STIM_DELAY-1];
  assign w_last      = (r_pos == POS_W'(WORD_LEN - 1));
  assign w_load_step = (bus.shift_count == '0) ? CNT_W'(1) : bus.shift_count;

  // Stimulus delay line; a shift-in form that also covers STIM_DELAY == 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_stim <= '0;
    else        r_stim <= (r_stim << 1) | STIM_DELAY'(w_stim);
  end

  // Digit position: d0 marks digit 0, so the following p.i. is digit 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_pos <= '0;
    else if (bus.d0) r_pos <= POS_W'(1);
    else if (w_last) r_pos <= '0;
    else             r_pos <= r_pos + POS_W'(1);
  end

  // Next-state, latched mode and step count.
  always_comb begin
    w_state_nxt = r_state;
    w_mode_nxt  = r_mode;
    w_step_nxt  = r_step;
    case (r_state)
      S_IDLE: begin
        if (w_ff_set && (bus.mode != M_RSV)) begin
          w_state_nxt = S_ARMED;
          w_mode_nxt  = mode_t'(bus.mode);
          w_step_nxt  = w_load_step;
        end
      end
      S_ARMED: begin
        if (w_abort)     w_state_nxt = S_DONE;
        else if (bus.d0) w_state_nxt = S_ACTIVE;
      end
      S_ACTIVE: begin
        if (w_abort) begin
          w_state_nxt = S_DONE;
        end else begin
          if (bus.d0 && (r_step > CNT_W'(1))) w_step_nxt = r_step - CNT_W'(1);
          if (w_last && (r_step == CNT_W'(1))) w_state_nxt = S_DONE;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register; outputs are decoded from the next state so they are
  // registered yet line up with the state they describe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_mode  <= M_MUL;
      r_step  <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_mult  <= 1'b0;
      r_shl   <= 1'b0;
      r_shr   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_mode  <= w_mode_nxt;
      r_step  <= w_step_nxt;
      r_busy  <= (w_state_nxt == S_ARMED) || (w_state_nxt == S_ACTIVE);
      r_done  <= (w_state_nxt == S_DONE);
      r_mult  <= (w_state_nxt == S_ACTIVE) && (w_mode_nxt == M_MUL);
      r_shl   <= (w_state_nxt == S_ACTIVE) && (w_mode_nxt == M_SHL);
      r_shr   <= (w_state_nxt == S_ACTIVE) && (w_mode_nxt == M_SHR);
    end
  end

  assign w_zero_d0     = r_busy & bus.d0;
  assign bus.zero_d0   = w_zero_d0;
  assign bus.ds        = bus.c7 & w_zero_d0;
  assign bus.da_m      = bus.c5 & bus.da;
  assign bus.g8        = ~r_busy;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.mult_step = r_mult;
  assign bus.shift_l   = r_shl;
  assign bus.shift_r   = r_shr;
  assign bus.digit_pos = r_pos;
endmodule
